// File: rtl/logic_pipe_issue_ctrl.sv
// ---------------------------------------------------------------------------
// logic_pipe_issue_ctrl
//
// Purpose:
//   Adapter between a ready/valid operation source and a fixed-latency,
//   valid-only logic pipeline that cannot stall. Operations are issued only
//   when a result slot is guaranteed (credit counting). Pipeline results are
//   collected in a small FIFO and presented on a ready/valid master port.
//   After reset, a short flush window discards stale results that are still
//   travelling through the un-reset pipeline.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   s_valid/s_ready               operation handshake (slave side)
//   s_opcode, s_a, s_b            operation fields
//   p_v_in, p_opcode, p_a, p_b    pipeline issue strobe and operands
//   p_v_out, p_out                pipeline result strobe and data
//   m_valid/m_ready, m_data       result handshake (master side)
//   err                           sticky protocol error flag
// ---------------------------------------------------------------------------
module logic_pipe_issue_ctrl #(
    parameter int WIDTH    = 32,
    parameter int PIPE_LAT = 2,
    parameter int DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [1:0]       s_opcode,
    input  logic [WIDTH-1:0] s_a,
    input  logic [WIDTH-1:0] s_b,
    output logic             p_v_in,
    output logic [1:0]       p_opcode,
    output logic [WIDTH-1:0] p_a,
    output logic [WIDTH-1:0] p_b,
    input  logic             p_v_out,
    input  logic [WIDTH-1:0] p_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int OW = $clog2(DEPTH + 1);
    localparam int CW = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

    typedef enum logic {ST_FLUSH, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     flush_cnt_q, flush_cnt_d;
    logic              run;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]     outstanding_q, outstanding_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic [PW-1:0]     occupancy;
    logic              empty, full;
    logic              issue, pop, pop_dec, wr_try, wr_en;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FLUSH;
            flush_cnt_q <= CW'(PIPE_LAT);
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // FLUSH spans PIPE_LAT+1 cycles: counts PIPE_LAT..0, leaves on 0.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q == ST_FLUSH) begin
            if (flush_cnt_q == '0) begin
                state_d = ST_RUN;
            end else begin
                flush_cnt_d = flush_cnt_q - CW'(1);
            end
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        run = 1'b0;
        if (state_q == ST_RUN) begin
            run = 1'b1;
        end
    end

    // ---------------- FIFO status ----------------
    assign occupancy = wr_ptr_q - rd_ptr_q;
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // s_ready uses registered state only, so no combinational path from
    // s_valid or m_ready reaches it.
    assign s_ready  = run && (outstanding_q < OW'(DEPTH));
    assign issue    = s_valid && s_ready;
    assign pop      = m_valid && m_ready;
    // An unexpected result can leave more entries than credits; never
    // let the credit counter wrap below zero in that case.
    assign pop_dec  = pop && (outstanding_q != '0);
    // Results during FLUSH belong to operations issued before reset.
    assign wr_try   = run && p_v_out;
    assign wr_en    = wr_try && (!full || pop);

    assign p_v_in   = issue;
    assign p_opcode = s_opcode;
    assign p_a      = s_a;
    assign p_b      = s_b;

    assign m_valid  = !empty;
    assign m_data   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign err      = err_q;

    // ---------------- next-state for datapath ----------------
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        outstanding_d = outstanding_q;
        err_d         = err_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        if (issue && !pop_dec) begin
            outstanding_d = outstanding_q + OW'(1);
        end else if (!issue && pop_dec) begin
            outstanding_d = outstanding_q - OW'(1);
        end

        // Overflow: pipeline delivered into a full FIFO with nothing leaving.
        if (wr_try && full && !pop) begin
            err_d = 1'b1;
        end
        // Unexpected: every credit is already accounted for by the FIFO.
        if (wr_try && (PW'(outstanding_q) == occupancy)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    // Storage needs no reset: emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= p_out;
        end
    end

endmodule
